// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Produces the pixel-rate strobe, the pixel clock to the DAC, the raster
// counters (DrawX/DrawY) and sync/blank outputs. The sync/blank outputs are
// delayed by PIPE_DELAY pixel periods to line up with downstream registered
// colour lookup.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);
  // PIPE_DELAY=0 still uses one per-Clk register stage.
  localparam int PD      = (PIPE_DELAY < 1) ? 1 : PIPE_DELAY;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          vga_clk_q;
  logic [PD-1:0] hs_pipe_q, hs_pipe_d;
  logic [PD-1:0] vs_pipe_q, vs_pipe_d;
  logic [PD-1:0] bl_pipe_q, bl_pipe_d;
  logic          hs_raw, vs_raw, blank_raw_n;

  assign pixel_en    = (div_q == DIV_LAST);
  assign frame_start = pixel_en && (hc_q == H_LAST) && (vc_q == V_LAST);

  assign hs_raw      = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vs_raw      = !((vc_q >= VS_START) && (vc_q < VS_END));
  assign blank_raw_n = (hc_q < H_VIS) && (vc_q < V_VIS);

  // Divider and raster counters advance together on the pixel strobe.
  always_comb begin
    div_d = div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pixel_en) begin
      div_d = '0;
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Sync/blank delay line; with no pixel delay it reloads every Clk.
  always_comb begin
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;
    bl_pipe_d = bl_pipe_q;
    if ((PIPE_DELAY == 0) || pixel_en) begin
      hs_pipe_d[0] = hs_raw;
      vs_pipe_d[0] = vs_raw;
      bl_pipe_d[0] = blank_raw_n;
      for (int i = 1; i < PD; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
        bl_pipe_d[i] = bl_pipe_q[i-1];
      end
    end
  end

  // State registers; reset forces every stage to its inactive level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      vga_clk_q <= 1'b0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      bl_pipe_q <= '0;
    end else begin
      div_q     <= div_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      vga_clk_q <= (div_d >= DIV_HALF);
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      bl_pipe_q <= bl_pipe_d;
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_pipe_q[PD-1];
  assign VGA_VS      = vs_pipe_q[PD-1];
  assign VGA_BLANK_N = bl_pipe_q[PD-1];
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: four instances (default timing and three
// reduced-raster variants with different divider / pipeline depths) are
// compared every cycle against an arithmetic model of the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pe;
    logic       vclk;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       sn;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [9:0] dx [4];
  logic [9:0] dy [4];
  logic vclk [4], hs [4], vs [4], bl [4], sn [4], pe [4], fs [4];
  exp_t got [4];

  vga_timing_gen u0 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
    .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sn[0]), .DrawX(dx[0]), .DrawY(dy[0]),
    .pixel_en(pe[0]), .frame_start(fs[0]));

  vga_timing_gen #(.H_VISIBLE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .CLK_DIV(2), .PIPE_DELAY(1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
    .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sn[1]), .DrawX(dx[1]), .DrawY(dy[1]),
    .pixel_en(pe[1]), .frame_start(fs[1]));

  vga_timing_gen #(.H_VISIBLE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .CLK_DIV(3), .PIPE_DELAY(3)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
    .VGA_BLANK_N(bl[2]), .VGA_SYNC_N(sn[2]), .DrawX(dx[2]), .DrawY(dy[2]),
    .pixel_en(pe[2]), .frame_start(fs[2]));

  vga_timing_gen #(.H_VISIBLE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .CLK_DIV(4), .PIPE_DELAY(0)) u3 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[3]), .VGA_HS(hs[3]), .VGA_VS(vs[3]),
    .VGA_BLANK_N(bl[3]), .VGA_SYNC_N(sn[3]), .DrawX(dx[3]), .DrawY(dy[3]),
    .pixel_en(pe[3]), .frame_start(fs[3]));

  // Collect each instance's outputs into one comparable word.
  always_comb begin
    for (int i = 0; i < 4; i++)
      got[i] = {dx[i], dy[i], pe[i], vclk[i], fs[i], hs[i], vs[i], bl[i], sn[i]};
  end

  int checks = 0;
  int errors = 0;
  int k = 0;
  exp_t sbq [4][$];

  // Instance configuration: divider, pixel delay, reduced raster or not.
  function automatic int cfg_div(int i);
    case (i) 0: return 2; 1: return 2; 2: return 3; default: return 4; endcase
  endfunction
  function automatic int cfg_pd(int i);
    case (i) 0: return 1; 1: return 1; 2: return 3; default: return 0; endcase
  endfunction

  function automatic exp_t rst_val();
    exp_t e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // Expected outputs after n Clk edges since reset release: the n-th edge
  // count maps to a pixel index, and sync/blank follow the pixel index
  // shifted back by the pipeline depth.
  function automatic exp_t model(int i, int n);
    int hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, d, p, pix, dpix, h, v;
    bit dvalid;
    exp_t e;
    if (i == 0) begin
      hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
    end else begin
      hv = 12; hf = 3; hsw = 5; hb = 4; vv = 6; vf = 2; vsw = 2; vb = 3;
    end
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    d = cfg_div(i);
    p = cfg_pd(i);
    pix = n / d;
    e = '0;
    e.hc = 10'(pix % ht);
    e.vc = 10'((pix / ht) % vt);
    e.pe = ((n % d) == d - 1);
    e.vclk = ((n % d) >= d / 2);
    e.fs = e.pe && ((pix % (ht * vt)) == ht * vt - 1);
    if (p == 0) begin
      dvalid = (n >= 1);
      dpix = (n - 1) / d;
    end else begin
      dvalid = (pix >= p);
      dpix = pix - p;
    end
    if (dvalid) begin
      h = dpix % ht;
      v = (dpix / ht) % vt;
      e.hs = !(h >= hv + hf && h < hv + hf + hsw);
      e.vs = !(v >= vv + vf && v < vv + vf + vsw);
      e.bl = (h < hv) && (v < vv);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bl = 1'b0;
    end
    e.sn = 1'b0;
    return e;
  endfunction

  task automatic compare(string name, int i, exp_t g, exp_t e);
    checks++;
    if (g !== e) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s dut%0d k=%0d got hc=%0d vc=%0d pe/vclk/fs/hs/vs/bl/sn=%b required hc=%0d vc=%0d pe/vclk/fs/hs/vs/bl/sn=%b",
                 name, i, k, g.hc, g.vc, {g.pe, g.vclk, g.fs, g.hs, g.vs, g.bl, g.sn},
                 e.hc, e.vc, {e.pe, e.vclk, e.fs, e.hs, e.vs, e.bl, e.sn});
    end
  endtask

  // Stimulus: advance the edge count and queue the model's prediction.
  task automatic run(int cycles);
    repeat (cycles) begin
      @(posedge Clk);
      if (Reset_n) begin
        k++;
        for (int i = 0; i < 4; i++) sbq[i].push_back(model(i, k));
      end
    end
  endtask

  task automatic pulse_reset(int cycles);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    for (int i = 0; i < 4; i++) sbq[i].delete();
    #1;
    for (int i = 0; i < 4; i++) compare("async_reset", i, got[i], rst_val());
    repeat (cycles) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
    k = 0;
  endtask

  // Monitor: every falling edge, pop one prediction per instance.
  always @(negedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!Reset_n) begin
        compare("in_reset", i, got[i], rst_val());
      end else if (sbq[i].size() == 0) begin
        if (k > 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow dut%0d k=%0d got empty queue required entry", i, k);
        end
      end else begin
        compare("raster", i, got[i], sbq[i].pop_front());
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
    k = 0;
    // Default raster: covers HS at 656, line wrap 799->0 and several lines.
    run(5000);
    for (int r = 0; r < 4; r++) begin
      pulse_reset($urandom_range(1, 3));
      run($urandom_range(200, 1500));
    end
    pulse_reset(1);
    run(2600);
    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
